conv_stream_mac: RTL and testbench

//   Sequential KxK convolution engine for the CNN accelerator datapath. Weights are

---
 rtl/conv_stream_mac_pkg.sv | 23 ++
 rtl/conv_stream_mac_pe.sv | 35 +++
 rtl/conv_stream_mac.sv | 133 +++++++++++++
 tb/tb_conv_stream_mac.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_mac_pkg.sv
// conv_pkg: shared types and sizing helpers for the streaming convolution engine.
//   state_t     : engine state (EMPTY -> LOAD -> RUN)
//   clog2_min1  : index width for an NW-entry counter, never below 1 bit
//   acc_width   : overflow-free accumulator width for DW-bit operands over K*K*C taps
package conv_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int acc_width(input int dw, input int k, input int c);
    return 2 * dw + $clog2(k * k * c);
  endfunction

endpackage

// File: rtl/conv_stream_mac_pe.sv
// conv_mac_pe: signed multiply-accumulate element.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the accumulator (has priority over en)
//   en       : fold the current product into the accumulator
//   a, b     : signed DW-bit operands
//   sum      : acc + sign-extended a*b (combinational), used for the final tap
module conv_mac_pe #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc;

  // Full-precision product; the size cast of a signed value sign-extends.
  assign prod = a * b;
  assign sum  = acc + ACC_W'(prod);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/conv_stream_mac.sv
// conv_stream_mac: sequential KxK, multi-channel convolution engine.
//   Weights stream in once per layer (wt_start, then NW words on wt_valid/wt_ready);
//   pixels then stream in the same order, one signed MAC per cycle. Each finished
//   window is registered onto out_valid/out_data (optionally ReLU-clamped) and held
//   until out_ready.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wt_start                      restart weight load (drops any partial window)
//   wt_valid, wt_data, wt_ready   weight stream
//   px_valid, px_data, px_ready   pixel stream
//   relu_en                       sampled with the last pixel of a window
//   out_valid, out_data, out_ready result stream (single output register)
//   weights_ok                    full weight set resident
module conv_stream_mac
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 1,
  parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, KERNEL_SIZE, CHANNELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wt_start,
  input  logic                        wt_valid,
  input  logic signed [DATA_WIDTH-1:0] wt_data,
  output logic                        wt_ready,
  input  logic                        px_valid,
  input  logic signed [DATA_WIDTH-1:0] px_data,
  output logic                        px_ready,
  input  logic                        relu_en,
  output logic                        out_valid,
  output logic signed [ACC_WIDTH-1:0] out_data,
  input  logic                        out_ready,
  output logic                        weights_ok
);

  localparam int NT    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NW    = NT * CHANNELS;
  localparam int IDX_W = clog2_min1(NW);

  state_t                        state, state_nxt;
  logic [IDX_W-1:0]              idx;
  logic signed [DATA_WIDTH-1:0]  wmem [NW];
  logic                          wt_fire, px_fire, last;
  logic signed [ACC_WIDTH-1:0]   sum;

  assign wt_fire = wt_valid && wt_ready;
  assign px_fire = px_valid && px_ready;
  assign last    = (idx == IDX_W'(NW - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (wt_start) begin
      state_nxt = LOAD;
    end else begin
      unique case (state)
        LOAD:    if (wt_fire && last) state_nxt = RUN;
        default: ;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // wt_start wins over any same-cycle transfer, so both readies drop with it.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    wt_ready = 1'b0;
    px_ready = 1'b0;
    unique case (state)
      LOAD:    wt_ready = !wt_start;
      RUN:     px_ready = !wt_start && !(out_valid && !out_ready);
      default: ;
    endcase
  end

  // ---------------- tap index and weight-set status ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      weights_ok <= 1'b0;
    end else if (wt_start) begin
      idx        <= '0;
      weights_ok <= 1'b0;
    end else if (wt_fire || px_fire) begin
      idx <= last ? '0 : idx + IDX_W'(1);
      if (wt_fire && last) weights_ok <= 1'b1;
    end
  end

  // ---------------- weight storage ----------------
  // NOTE: the weight array is deliberately not reset; weights_ok gates its use,
  // and leaving it out of reset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (wt_fire) wmem[idx] <= wt_data;
  end

  // ---------------- MAC ----------------
  conv_mac_pe #(
    .DW    (DATA_WIDTH),
    .ACC_W (ACC_WIDTH)
  ) u_pe (
    .clk (clk),
    .rst (rst),
    .clr (wt_start || (px_fire && last)),
    .en  (px_fire),
    .a   (px_data),
    .b   (wmem[idx]),
    .sum (sum)
  );

  // ---------------- output register ----------------
  // A new result and a same-cycle consume leave out_valid set with fresh data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (px_fire && last) begin
      out_valid <= 1'b1;
      out_data  <= (relu_en && sum[ACC_WIDTH-1]) ? '0 : sum;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_stream_mac.sv
// Directed bench for conv_stream_mac: a K=3/C=1 instance for most scenarios and a
// K=3/C=2 instance for channel accumulation. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_conv_stream_mac;

  localparam int DW  = 8;
  localparam int AW1 = 20;  // 16 + clog2(9)
  localparam int AW2 = 21;  // 16 + clog2(18)

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT 1 (C=1)
  logic                 wt_start, wt_valid, wt_ready;
  logic signed [DW-1:0] wt_data;
  logic                 px_valid, px_ready, relu_en;
  logic signed [DW-1:0] px_data;
  logic                 out_valid, out_ready, weights_ok;
  logic signed [AW1-1:0] out_data;

  // DUT 2 (C=2)
  logic                 wt_start2, wt_valid2, wt_ready2;
  logic signed [DW-1:0] wt_data2;
  logic                 px_valid2, px_ready2;
  logic signed [DW-1:0] px_data2;
  logic                 out_valid2, weights_ok2;
  logic signed [AW2-1:0] out_data2;

  conv_stream_mac #(.KERNEL_SIZE(3), .DATA_WIDTH(DW), .CHANNELS(1)) u_dut (
    .clk(clk), .rst(rst),
    .wt_start(wt_start), .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .relu_en(relu_en),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .weights_ok(weights_ok)
  );

  conv_stream_mac #(.KERNEL_SIZE(3), .DATA_WIDTH(DW), .CHANNELS(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .wt_start(wt_start2), .wt_valid(wt_valid2), .wt_data(wt_data2), .wt_ready(wt_ready2),
    .px_valid(px_valid2), .px_data(px_data2), .px_ready(px_ready2),
    .relu_en(1'b0),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(1'b1),
    .weights_ok(weights_ok2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic signed [DW-1:0] wv [9];
  logic signed [DW-1:0] pv [9];

  // Pulse wt_start, then stream the 9 weights in wv (always accepted in LOAD).
  task automatic load_weights();
    @(negedge clk);
    wt_start = 1'b1;
    @(negedge clk);
    wt_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wt_valid = 1'b1;
      wt_data  = wv[i];
      @(negedge clk);
    end
    wt_valid = 1'b0;
  endtask

  // Stream the first n pixels of pv, waiting (bounded) on px_ready for each one.
  task automatic send_px(input int n, input logic relu);
    int waits;
    for (int i = 0; i < n; i++) begin
      px_valid = 1'b1;
      px_data  = pv[i];
      relu_en  = relu;
      #1;
      waits = 0;
      while (!px_ready && waits < 50) begin
        @(negedge clk);
        #1;
        waits++;
      end
      if (!px_ready) begin
        check("px_ready_timeout", 0, 1);
        px_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    px_valid = 1'b0;
  endtask

  task automatic fill(input int wbase, input int wstep, input int pbase, input int pstep);
    for (int i = 0; i < 9; i++) begin
      wv[i] = DW'(wbase + wstep * i);
      pv[i] = DW'(pbase + pstep * i);
    end
  endtask

  int nres, stalls;

  initial begin
    rst = 1'b1;
    wt_start = 0; wt_valid = 0; wt_data = 0;
    px_valid = 0; px_data = 0; relu_en = 0; out_ready = 1;
    wt_start2 = 0; wt_valid2 = 0; wt_data2 = 0; px_valid2 = 0; px_data2 = 0;
    repeat (2) @(negedge clk);

    // ---- reset state ----
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_weights_ok", weights_ok, 0);
    check("rst_wt_ready", wt_ready, 0);
    check("rst_px_ready", px_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- 1: weights 1..9, pixels all 1 -> 45 one cycle after the 9th pixel ----
    fill(1, 1, 1, 0);
    load_weights();
    check("t1_weights_ok", weights_ok, 1);
    send_px(8, 0);
    check("t1_no_early_valid", out_valid, 0);
    send_px(1, 0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 45);
    @(negedge clk);
    check("t1_consumed", out_valid, 0);

    // ---- 2: weights -1, pixels 2 -> -18, ReLU -> 0 ----
    fill(-1, 0, 2, 0);
    load_weights();
    send_px(9, 0);
    check("t2_signed", out_data, -18);
    send_px(9, 1);
    check("t2_relu", out_data, 0);
    check("t2_relu_valid", out_valid, 1);

    // ---- 3: C=2, ch0 weights 1, ch1 weights 2, pixels 3 -> 81 ----
    @(negedge clk);
    wt_start2 = 1'b1;
    @(negedge clk);
    wt_start2 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wt_valid2 = 1'b1;
      wt_data2  = (i < 9) ? 8'sd1 : 8'sd2;
      @(negedge clk);
    end
    wt_valid2 = 1'b0;
    check("t3_weights_ok", weights_ok2, 1);
    stalls = 0;
    for (int i = 0; i < 18; i++) begin
      px_valid2 = 1'b1;
      px_data2  = 8'sd3;
      #1;
      if (!px_ready2) stalls++;
      @(negedge clk);
    end
    px_valid2 = 1'b0;
    check("t3_stalls", stalls, 0);
    check("t3_out_valid", out_valid2, 1);
    check("t3_out_data", out_data2, 81);

    // ---- 4: backpressure, weights 1..9 ----
    fill(1, 1, 1, 1);
    load_weights();
    out_ready = 1'b0;
    send_px(9, 0);                         // 1*1+..+9*9 = 285
    check("t4_first", out_data, 285);
    px_valid = 1'b1;
    px_data  = 8'sd9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_px_ready_stalled", px_ready, 0);
      check("t4_held_valid", out_valid, 1);
      check("t4_held_data", out_data, 285);
    end
    out_ready = 1'b1;
    fill(1, 1, 9, -1);                     // pixels 9..1 -> 165
    send_px(9, 0);
    check("t4_second_valid", out_valid, 1);
    check("t4_second", out_data, 165);
    repeat (2) @(negedge clk);

    // ---- 5: 4 back-to-back windows, pixels k+1 -> 45*(k+1) ----
    nres = 0;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("t5_result", out_data, 45 * (nres + 1));
        nres++;
      end
      if (c < 36) begin
        px_valid = 1'b1;
        px_data  = DW'(c / 9 + 1);
        #1;
        if (!px_ready) stalls++;
      end else begin
        px_valid = 1'b0;
      end
    end
    check("t5_count", nres, 4);
    check("t5_stalls", stalls, 0);

    // ---- 6a: async reset at tap 5 ----
    fill(1, 1, 1, 0);
    send_px(5, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_weights_ok", weights_ok, 0);
    check("t6_rst_px_ready", px_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- 6b: wt_start mid-window drops the partial sum ----
    load_weights();
    send_px(4, 0);
    fill(1, 0, 1, 0);
    @(negedge clk);
    wt_start = 1'b1;
    #1;
    check("t6_start_px_ready", px_ready, 0);
    @(negedge clk);
    wt_start = 1'b0;
    check("t6_reload_weights_ok", weights_ok, 0);
    for (int i = 0; i < 9; i++) begin
      wt_valid = 1'b1;
      wt_data  = wv[i];
      @(negedge clk);
    end
    wt_valid = 1'b0;
    send_px(9, 0);
    check("t6_after_abort", out_data, 9);

    // ---- 6c: max-negative operands ----
    fill(-128, 0, -128, 0);
    load_weights();
    send_px(9, 0);
    check("t6_maxneg_pos", out_data, 147456);
    fill(-128, 0, 127, 0);
    send_px(9, 0);
    check("t6_maxneg_neg", out_data, -146304);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
